// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared constants for TLB maintenance: op encodings, INVTLB codes, page sizes, FSM states.
package tlb_maint_ctrl_pkg;

  localparam int unsigned TLBNUM_DEF = 16;

  // req_op encodings
  localparam logic [1:0] TLBOP_WR   = 2'd0;
  localparam logic [1:0] TLBOP_FILL = 2'd1;
  localparam logic [1:0] TLBOP_INV  = 2'd2;
  localparam logic [1:0] TLBOP_RSVD = 2'd3;

  // INVTLB op codes
  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;

  // Page sizes (log2 bytes)
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB match: decides whether the entry on the read port is hit by inv_op.
module tlb_inv_match
  import tlb_maint_ctrl_pkg::*;
(
  input  logic [4:0]  inv_op,
  input  logic [9:0]  inv_asid,
  input  logic [18:0] inv_vppn,
  input  logic        r_g,
  input  logic [9:0]  r_asid,
  input  logic [18:0] r_vppn,
  input  logic [5:0]  r_ps,
  output logic        match
);

  logic asid_eq;
  logic va_eq;

  assign asid_eq = (r_asid == inv_asid);
  // 4M pages ignore the low 9 VPPN bits; anything else compares the full VPPN
  assign va_eq   = (r_ps == PS_4M) ? (r_vppn[18:9] == inv_vppn[18:9]) : (r_vppn == inv_vppn);

  // Decode the invalidation rule selected by inv_op
  always_comb begin
    match = 1'b0;
    unique case (inv_op)
      INV_ALL0, INV_ALL1: match = 1'b1;
      INV_G:              match = r_g;
      INV_NG:             match = ~r_g;
      INV_NG_ASID:        match = ~r_g & asid_eq;
      INV_NG_ASID_VA:     match = ~r_g & asid_eq & va_eq;
      INV_GA_VA:          match = (r_g | asid_eq) & va_eq;
      default:            match = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: owns the TLB write port, serves TLBWR/TLBFILL in one cycle and
// walks every entry for INVTLB. Optional macro TLB_MAINT_PERF_CNT_EN adds the inv_cnt output.
module tlb_maint_ctrl
  import tlb_maint_ctrl_pkg::*;
#(
  parameter int unsigned TLBNUM = TLBNUM_DEF,
  parameter int unsigned IDX_W  = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [18:0]      inv_vppn,
  input  logic [IDX_W-1:0] csr_tlbidx_index,
  output logic             req_ready,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] r_index,
  input  logic             r_e,
  input  logic             r_g,
  input  logic [9:0]       r_asid,
  input  logic [18:0]      r_vppn,
  input  logic [5:0]       r_ps,
  output logic             we,
  output logic [IDX_W-1:0] w_index,
  output logic             w_clr_only
`ifdef TLB_MAINT_PERF_CNT_EN
  ,
  output logic [31:0]      inv_cnt
`endif
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TLBNUM - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rand_q, rand_d;
  logic             match;

  tlb_inv_match u_match (
    .inv_op   (inv_op),
    .inv_asid (inv_asid),
    .inv_vppn (inv_vppn),
    .r_g      (r_g),
    .r_asid   (r_asid),
    .r_vppn   (r_vppn),
    .r_ps     (r_ps),
    .match    (match)
  );

  // Next state: FSM transitions, scan counter and free-running fill index generator
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // X <= 5X + 13, truncated to IDX_W bits
    rand_d  = (rand_q << 2) + rand_q + IDX_W'(13);
    unique case (state_q)
      StIdle: begin
        if (req_valid && (req_op == TLBOP_INV)) begin
          cnt_d = '0;
          // Illegal inv_op only retires; decode has already raised INE
          state_d = (inv_op <= INV_GA_VA) ? StScan : StDone;
        end
      end
      StScan: begin
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset mid-scan abandons the walk immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rand_q  <= IDX_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rand_q  <= rand_d;
    end
  end

  // Output decode; TLBWR/TLBFILL write in the accept cycle, scan writes are clear-only
  always_comb begin
    req_ready  = (state_q == StIdle);
    busy       = (state_q == StScan);
    done       = (state_q == StDone);
    r_index    = cnt_q;
    we         = 1'b0;
    w_clr_only = 1'b0;
    w_index    = csr_tlbidx_index;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op == TLBOP_WR) begin
            we = 1'b1;
          end else if (req_op == TLBOP_FILL) begin
            we      = 1'b1;
            w_index = rand_q;
          end
        end
      end
      StScan: begin
        we         = r_e & match;
        w_clr_only = 1'b1;
        w_index    = cnt_q;
      end
      default: ;
    endcase
  end

`ifdef TLB_MAINT_PERF_CNT_EN
  logic [31:0] inv_cnt_q, inv_cnt_d;

  // Count entries cleared by INVTLB, saturating at all-ones
  always_comb begin
    inv_cnt_d = inv_cnt_q;
    if (we && w_clr_only && (inv_cnt_q != 32'hFFFF_FFFF)) begin
      inv_cnt_d = inv_cnt_q + 32'd1;
    end
  end

  // Perf counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inv_cnt_q <= '0;
    end else begin
      inv_cnt_q <= inv_cnt_d;
    end
  end

  assign inv_cnt = inv_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Randomized self-checking bench for tlb_maint_ctrl with a behavioural TLB and reference model.
module tb_tlb_maint_ctrl;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;

  logic              clk;
  logic              resetn;
  logic              req_valid;
  logic [1:0]        req_op;
  logic [4:0]        inv_op;
  logic [9:0]        inv_asid;
  logic [18:0]       inv_vppn;
  logic [IDX_W-1:0]  csr_tlbidx_index;
  logic              req_ready;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  r_index;
  logic              r_e;
  logic              r_g;
  logic [9:0]        r_asid;
  logic [18:0]       r_vppn;
  logic [5:0]        r_ps;
  logic              we;
  logic [IDX_W-1:0]  w_index;
  logic              w_clr_only;
`ifdef TLB_MAINT_PERF_CNT_EN
  logic [31:0]       inv_cnt;
`endif

  // Behavioural TLB contents
  logic        tlb_e    [TLBNUM];
  logic        tlb_g    [TLBNUM];
  logic [9:0]  tlb_asid [TLBNUM];
  logic [18:0] tlb_vppn [TLBNUM];
  logic [5:0]  tlb_ps   [TLBNUM];

  int n_checks = 0;
  int n_fail   = 0;
  int m_rand;
  int m_inv_cnt = 0;

  tlb_maint_ctrl #(
    .TLBNUM (TLBNUM),
    .IDX_W  (IDX_W)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_valid        (req_valid),
    .req_op           (req_op),
    .inv_op           (inv_op),
    .inv_asid         (inv_asid),
    .inv_vppn         (inv_vppn),
    .csr_tlbidx_index (csr_tlbidx_index),
    .req_ready        (req_ready),
    .busy             (busy),
    .done             (done),
    .r_index          (r_index),
    .r_e              (r_e),
    .r_g              (r_g),
    .r_asid           (r_asid),
    .r_vppn           (r_vppn),
    .r_ps             (r_ps),
    .we               (we),
    .w_index          (w_index),
    .w_clr_only       (w_clr_only)
`ifdef TLB_MAINT_PERF_CNT_EN
    ,
    .inv_cnt          (inv_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign r_e    = tlb_e[r_index];
  assign r_g    = tlb_g[r_index];
  assign r_asid = tlb_asid[r_index];
  assign r_vppn = tlb_vppn[r_index];
  assign r_ps   = tlb_ps[r_index];

  // TLB write port: full writes mark the entry valid, clear-only writes drop E
  always @(posedge clk) begin
    if (resetn && we) begin
      tlb_e[w_index] <= !w_clr_only;
    end
  end

  // Reference fill-index sequence
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_rand <= 1;
    else         m_rand <= (5 * m_rand + 13) % TLBNUM;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TLBNUM-1:0] e_vec();
    logic [TLBNUM-1:0] v;
    for (int i = 0; i < TLBNUM; i++) v[i] = tlb_e[i];
    return v;
  endfunction

  // Does INVTLB (op, asid, vppn) hit entry i, irrespective of its E bit
  function automatic bit inv_hits(input logic [4:0] op, input logic [9:0] asid,
                                  input logic [18:0] vppn, input int i);
    bit aeq, veq;
    aeq = (tlb_asid[i] == asid);
    if (tlb_ps[i] == 6'd21) veq = (tlb_vppn[i] >> 9) == (vppn >> 9);
    else                    veq = (tlb_vppn[i] == vppn);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return tlb_g[i];
      5'd3:       return !tlb_g[i];
      5'd4:       return !tlb_g[i] && aeq;
      5'd5:       return !tlb_g[i] && aeq && veq;
      5'd6:       return (tlb_g[i] || aeq) && veq;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [9:0] pick_asid();
    return ($urandom_range(0, 2) == 0) ? 10'($urandom) : 10'h012;
  endfunction

  function automatic logic [18:0] pick_vppn();
    case ($urandom_range(0, 3))
      0:       return 19'h00401;
      1:       return 19'h00400;
      2:       return 19'h00601;
      default: return 19'($urandom);
    endcase
  endfunction

  task automatic rand_tlb();
    @(negedge clk);
    for (int i = 0; i < TLBNUM; i++) begin
      tlb_e[i]    <= 1'($urandom_range(0, 1));
      tlb_g[i]    <= 1'($urandom_range(0, 1));
      tlb_asid[i] <= pick_asid();
      tlb_vppn[i] <= pick_vppn();
      tlb_ps[i]   <= ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    req_valid = 1'b0;
    csr_tlbidx_index = 4'd9;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_clr", 32'(w_clr_only), 32'd0);
    check_eq("rst_rindex", 32'(r_index), 32'd0);
    check_eq("rst_windex", 32'(w_index), 32'd9);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Single-cycle TLBWR / TLBFILL / reserved op
  task automatic run_simple(input logic [1:0] op, input logic [IDX_W-1:0] idx);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    csr_tlbidx_index = idx;
    #1;
    check_eq("simple_ready", 32'(req_ready), 32'd1);
    check_eq("simple_busy", 32'(busy), 32'd0);
    if (op == 2'd3) begin
      check_eq("rsvd_we", 32'(we), 32'd0);
    end else begin
      check_eq("wr_we", 32'(we), 32'd1);
      check_eq("wr_clr", 32'(w_clr_only), 32'd0);
      check_eq("wr_index", 32'(w_index), (op == 2'd1) ? 32'(m_rand) : 32'(idx));
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // INVTLB; hold keeps req_valid asserted through the scan
  task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
                         input bit hold);
    logic [TLBNUM-1:0] snap, hitv;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'd2;
    inv_op = op;
    inv_asid = asid;
    inv_vppn = vppn;
    #1;
    snap = e_vec();
    for (int i = 0; i < TLBNUM; i++) hitv[i] = snap[i] && inv_hits(op, asid, vppn, i);
    check_eq("inv_acc_ready", 32'(req_ready), 32'd1);
    check_eq("inv_acc_we", 32'(we), 32'd0);
    check_eq("inv_acc_busy", 32'(busy), 32'd0);
    if (op <= 5'd6) begin
      for (int k = 0; k < TLBNUM; k++) begin
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        #1;
        check_eq("scan_busy", 32'(busy), 32'd1);
        check_eq("scan_ready", 32'(req_ready), 32'd0);
        check_eq("scan_done", 32'(done), 32'd0);
        check_eq("scan_rindex", 32'(r_index), 32'(k));
        check_eq("scan_windex", 32'(w_index), 32'(k));
        check_eq("scan_clr", 32'(w_clr_only), 32'd1);
        check_eq("scan_we", 32'(we), 32'(hitv[k]));
      end
    end
    @(negedge clk);
    #1;
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_ready", 32'(req_ready), 32'd0);
    check_eq("done_we", 32'(we), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("post_done", 32'(done), 32'd0);
    check_eq("post_ready", 32'(req_ready), 32'd1);
    check_eq("inv_result_e", 32'(e_vec()), 32'(snap & ~hitv));
    m_inv_cnt += $countones(hitv);
  endtask

  task automatic set_all_valid();
    @(negedge clk);
    for (int i = 0; i < TLBNUM; i++) tlb_e[i] <= 1'b1;
    #1;
  endtask

  initial begin
    logic [IDX_W-1:0] fill_seq [3];
    fill_seq[0] = 4'd2;
    fill_seq[1] = 4'd7;
    fill_seq[2] = 4'd0;
    resetn = 1'b0;
    req_valid = 1'b0;
    req_op = 2'd0;
    inv_op = 5'd0;
    inv_asid = '0;
    inv_vppn = '0;
    csr_tlbidx_index = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      tlb_e[i] = 1'b0;
      tlb_g[i] = 1'b0;
      tlb_asid[i] = '0;
      tlb_vppn[i] = '0;
      tlb_ps[i] = 6'd12;
    end

    do_reset();
    m_inv_cnt = 0;

    // Three back-to-back TLBFILL right after reset
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 2'd1;
      #1;
      check_eq("fill_seq_we", 32'(we), 32'd1);
      check_eq("fill_seq_index", 32'(w_index), 32'(fill_seq[j]));
    end
    @(negedge clk);
    req_valid = 1'b0;

    run_simple(2'd0, 4'd5);

    // INVTLB op 0 with every entry valid
    set_all_valid();
    run_inv(5'd0, 10'h0, 19'h0, 1'b0);
    check_eq("inv0_all_clear", 32'(e_vec()), 32'd0);

    // INVTLB op 5 directed entries
    @(negedge clk);
    for (int i = 0; i < TLBNUM; i++) tlb_e[i] <= 1'b0;
    tlb_e[3] <= 1'b1; tlb_g[3] <= 1'b0; tlb_asid[3] <= 10'h012;
    tlb_ps[3] <= 6'd12; tlb_vppn[3] <= 19'h00401;
    tlb_e[7] <= 1'b1; tlb_g[7] <= 1'b1; tlb_asid[7] <= 10'h012;
    tlb_ps[7] <= 6'd12; tlb_vppn[7] <= 19'h00401;
    tlb_e[9] <= 1'b1; tlb_g[9] <= 1'b0; tlb_asid[9] <= 10'h034;
    tlb_ps[9] <= 6'd21; tlb_vppn[9] <= 19'h00400;
    #1;
    run_inv(5'd5, 10'h012, 19'h00401, 1'b0);
    check_eq("inv5_e3", 32'(tlb_e[3]), 32'd0);
    check_eq("inv5_e7", 32'(tlb_e[7]), 32'd1);
    check_eq("inv5_e9", 32'(tlb_e[9]), 32'd1);

    // req_valid held throughout a scan
    rand_tlb();
    run_inv(5'd3, pick_asid(), pick_vppn(), 1'b1);

    // Reset while the scan is at entry 8
    set_all_valid();
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'd2;
    inv_op = 5'd0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    #1;
    check_eq("midrst_rindex", 32'(r_index), 32'd8);
    resetn = 1'b0;
    m_inv_cnt = 0;
    #1;
    check_eq("midrst_we", 32'(we), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("midrst_partial", 32'(e_vec()), 32'h0000_FF00);
    resetn = 1'b1;

    // Illegal inv_op only retires
    rand_tlb();
    run_inv(5'd7, 10'h012, 19'h00401, 1'b0);

    // Randomized mix of operations
    for (int n = 0; n < 40; n++) begin
      int kind;
      rand_tlb();
      kind = $urandom_range(0, 5);
      case (kind)
        0:       run_simple(2'd0, 4'($urandom));
        1:       run_simple(2'd1, 4'($urandom));
        2:       run_simple(2'd3, 4'($urandom));
        default: run_inv(5'($urandom_range(0, 9)), pick_asid(), pick_vppn(),
                         $urandom_range(0, 1) != 0);
      endcase
    end

`ifdef TLB_MAINT_PERF_CNT_EN
    check_eq("perf_inv_cnt", inv_cnt, 32'(m_inv_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
